// File: rtl/load_use_hazard_unit_if.sv
// Bus bundle between the ID-stage hazard unit and the pipeline control logic.
// The pipeline drives operand/EX information (master); the hazard unit answers with stall controls (slave).
interface load_use_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 3,
  parameter int CNT_W   = 16
);
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     ex_mem_read;
  logic [REG_W-1:0]         ex_dest;
  logic                     ex_dest_valid;
  logic                     mem_stall;
  logic                     clear_counts;
  logic                     stall_id;
  logic                     bubble_ex;
  logic [CNT_W-1:0]         hazard_count;
  logic [CNT_W-1:0]         bubble_count;

  modport master (
    output id_valid, id_src, id_src_used, ex_mem_read, ex_dest, ex_dest_valid,
           mem_stall, clear_counts,
    input  stall_id, bubble_ex, hazard_count, bubble_count
  );

  modport slave (
    input  id_valid, id_src, id_src_used, ex_mem_read, ex_dest, ex_dest_valid,
           mem_stall, clear_counts,
    output stall_id, bubble_ex, hazard_count, bubble_count
  );
endinterface

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector and multi-cycle bubble sequencer for the LC-3b ID stage.
// Define HAZARD_PERF_CNT_EN to build the saturating hazard/bubble performance counters.
module load_use_hazard_unit #(
  parameter int NUM_SRC      = 2,
  parameter int REG_W        = 3,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_use_hazard_unit_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       src_match;
  logic       hit;
  logic       stall;
  logic       bubble;
  logic       count_hazard;

  // R0 is an ordinary register here, so every used operand is compared.
  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && (bus.id_src[i*REG_W +: REG_W] == bus.ex_dest))
        src_match = 1'b1;
    end
  end

  assign hit = bus.id_valid & bus.ex_mem_read & bus.ex_dest_valid & src_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    stall        = 1'b0;
    bubble       = 1'b0;
    count_hazard = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_stall) begin
          stall = 1'b1;
        end else if (hit) begin
          stall        = 1'b1;
          bubble       = 1'b1;
          count_hazard = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nxt = STALL;
            rem_nxt   = REM_INIT;
          end
        end
      end
      STALL: begin
        // A cache stall freezes the bubble sequence without consuming a bubble.
        stall = 1'b1;
        if (!bus.mem_stall) begin
          bubble  = 1'b1;
          rem_nxt = rem - 4'd1;
          if (rem == 4'd1)
            state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rst_n) begin
      stall        = 1'b0;
      bubble       = 1'b0;
      count_hazard = 1'b0;
    end
  end

  assign bus.stall_id  = stall;
  assign bus.bubble_ex = bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear_counts) begin
      hazard_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (count_hazard && (hazard_cnt != {CNT_W{1'b1}}))
        hazard_cnt <= hazard_cnt + CNT_W'(1);
      if (bubble && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.hazard_count = hazard_cnt;
  assign bus.bubble_count = bubble_cnt;
`else
  logic unused_clear_counts;
  logic unused_count_hazard;

  assign unused_clear_counts = bus.clear_counts;
  assign unused_count_hazard = count_hazard;
  assign bus.hazard_count    = '0;
  assign bus.bubble_count    = '0;
`endif

endmodule
